// File: rtl/uart_z80_port.sv
// Z80 I/O port bridge for the UART: CPU strobe synchronisation, one-byte RX
// prefetch latch, TX ring buffer and the request/acknowledge FSM towards the transmitter.
module uart_z80_port #(
    parameter logic [7:0]  DATA_PORT    = 8'hF8,
    parameter logic [7:0]  STAT_PORT    = 8'hF9,
    parameter int unsigned TXQ_BITS     = 2,
    parameter int unsigned BUSY_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] z80_addr,
    input  logic [7:0] z80_din,
    input  logic       z80_iorq_n,
    input  logic       z80_rd_n,
    input  logic       z80_wr_n,
    input  logic       z80_m1_n,
    output logic [7:0] z80_dout,
    output logic       z80_dout_en,
    input  logic [7:0] uart_dataout,
    input  logic       uart_avail,
    input  logic       uart_buf_full,
    output logic       uart_read,
    output logic [7:0] uart_datain,
    output logic       uart_write,
    input  logic       uart_tx_ready
);
    localparam int unsigned TXQ_DEPTH = 1 << TXQ_BITS;
    localparam int unsigned TMR_W     = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [TXQ_BITS:0] PTR_ZERO = {(TXQ_BITS + 1){1'b0}};
    localparam logic [TXQ_BITS:0] PTR_ONE  = {{TXQ_BITS{1'b0}}, 1'b1};
    localparam logic [TMR_W-1:0]  TMR_ZERO = {TMR_W{1'b0}};
    localparam logic [TMR_W-1:0]  TMR_ONE  = {{(TMR_W - 1){1'b0}}, 1'b1};
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        TX_IDLE       = 2'd0,
        TX_WAIT_BUSY  = 2'd1,
        TX_WAIT_READY = 2'd2
    } tx_state_e;

    logic [1:0]        iorq_sync_q, rd_sync_q, wr_sync_q, m1_sync_q;
    logic              io_rd_prev_q, io_wr_prev_q;
    logic              io_rd_s, io_wr_s, rd_end_s, wr_start_s, io_rd_raw_s;

    logic              rx_valid_q;
    logic [7:0]        rx_latch_q;
    logic              uart_read_q;
    logic              rx_fill_s;

    logic [7:0]        txq_mem_q [TXQ_DEPTH];
    logic [TXQ_BITS:0] wr_ptr_q, rd_ptr_q;
    logic              txq_empty_s, txq_full_s, txq_push_s, txq_drop_s;
    logic              tx_ovf_q;

    tx_state_e         tx_state_q;
    logic [TMR_W-1:0]  timer_q;
    logic              uart_write_q;
    logic [7:0]        uart_datain_q;

    // Two-flop synchronisers for the CPU strobes plus edge-detect history.
    always_ff @(posedge clk) begin
        if (reset) begin
            iorq_sync_q  <= 2'b11;
            rd_sync_q    <= 2'b11;
            wr_sync_q    <= 2'b11;
            m1_sync_q    <= 2'b11;
            io_rd_prev_q <= 1'b0;
            io_wr_prev_q <= 1'b0;
        end else begin
            iorq_sync_q  <= {iorq_sync_q[0], z80_iorq_n};
            rd_sync_q    <= {rd_sync_q[0], z80_rd_n};
            wr_sync_q    <= {wr_sync_q[0], z80_wr_n};
            m1_sync_q    <= {m1_sync_q[0], z80_m1_n};
            io_rd_prev_q <= io_rd_s;
            io_wr_prev_q <= io_wr_s;
        end
    end

    // M1 low with IORQ is an interrupt acknowledge and never a port access.
    assign io_rd_s    = ~iorq_sync_q[1] & ~rd_sync_q[1] & m1_sync_q[1];
    assign io_wr_s    = ~iorq_sync_q[1] & ~wr_sync_q[1] & m1_sync_q[1];
    assign rd_end_s   = io_rd_prev_q & ~io_rd_s;
    assign wr_start_s = io_wr_s & ~io_wr_prev_q;

    assign io_rd_raw_s = ~z80_iorq_n & ~z80_rd_n & z80_m1_n;
    assign z80_dout_en = io_rd_raw_s & ((z80_addr == DATA_PORT) | (z80_addr == STAT_PORT));

    // Read mux works straight from the CPU pins so data is valid within the IN cycle.
    always_comb begin
        z80_dout = 8'h00;
        if (z80_addr == DATA_PORT) begin
            z80_dout = rx_valid_q ? rx_latch_q : 8'h00;
        end else if (z80_addr == STAT_PORT) begin
            z80_dout = {3'b000, tx_ovf_q, uart_buf_full, txq_empty_s, ~txq_full_s, rx_valid_q};
        end else begin
            z80_dout = 8'h00;
        end
    end

    assign rx_fill_s = ~rx_valid_q & uart_avail;

    // RX prefetch: grab the FIFO head into the latch, then pop it the following cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_valid_q  <= 1'b0;
            rx_latch_q  <= 8'h00;
            uart_read_q <= 1'b0;
        end else begin
            uart_read_q <= rx_fill_s;
            if (rx_fill_s) begin
                rx_latch_q <= uart_dataout;
                rx_valid_q <= 1'b1;
            end else if (rd_end_s && (z80_addr == DATA_PORT)) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

    assign txq_empty_s = (wr_ptr_q == rd_ptr_q);
    assign txq_full_s  = (wr_ptr_q[TXQ_BITS] != rd_ptr_q[TXQ_BITS]) &&
                         (wr_ptr_q[TXQ_BITS-1:0] == rd_ptr_q[TXQ_BITS-1:0]);
    assign txq_push_s  = wr_start_s & (z80_addr == DATA_PORT) & ~txq_full_s;
    assign txq_drop_s  = wr_start_s & (z80_addr == DATA_PORT) & txq_full_s;

    // Queue storage has no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (txq_push_s) begin
            txq_mem_q[wr_ptr_q[TXQ_BITS-1:0]] <= z80_din;
        end
    end

    // Write pointer and sticky overflow flag; a status read clears the flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= PTR_ZERO;
            tx_ovf_q <= 1'b0;
        end else begin
            if (txq_push_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (txq_drop_s) begin
                tx_ovf_q <= 1'b1;
            end else if (rd_end_s && (z80_addr == STAT_PORT)) begin
                tx_ovf_q <= 1'b0;
            end
        end
    end

    // TX handshake: raise write, pop only once the transmitter goes busy, else retry.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q    <= TX_IDLE;
            timer_q       <= TMR_ZERO;
            uart_write_q  <= 1'b0;
            uart_datain_q <= 8'h00;
            rd_ptr_q      <= PTR_ZERO;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    if (!txq_empty_s && uart_tx_ready) begin
                        uart_datain_q <= txq_mem_q[rd_ptr_q[TXQ_BITS-1:0]];
                        uart_write_q  <= 1'b1;
                        timer_q       <= TMR_ZERO;
                        tx_state_q    <= TX_WAIT_BUSY;
                    end
                end
                TX_WAIT_BUSY: begin
                    if (!uart_tx_ready) begin
                        uart_write_q <= 1'b0;
                        rd_ptr_q     <= rd_ptr_q + PTR_ONE;
                        tx_state_q   <= TX_WAIT_READY;
                    end else if (timer_q == TMR_LAST) begin
                        uart_write_q <= 1'b0;
                        tx_state_q   <= TX_IDLE;
                    end else begin
                        timer_q <= timer_q + TMR_ONE;
                    end
                end
                TX_WAIT_READY: begin
                    if (uart_tx_ready) begin
                        tx_state_q <= TX_IDLE;
                    end
                end
                default: begin
                    uart_write_q <= 1'b0;
                    tx_state_q   <= TX_IDLE;
                end
            endcase
        end
    end

    assign uart_read   = uart_read_q;
    assign uart_write  = uart_write_q;
    assign uart_datain = uart_datain_q;

endmodule

// File: tb/tb_uart_z80_port.sv
// Bench for uart_z80_port: queue-based model of the RX stream, TX queue and
// status flags, an RX FIFO and transmitter emulation, and directed CPU cycles.
module tb_uart_z80_port;
    localparam logic [7:0] DATA = 8'hF8;
    localparam logic [7:0] STAT = 8'hF9;
    localparam int M_NORMAL = 0;
    localparam int M_STALL  = 1;
    localparam int M_DEAF   = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] z80_addr, z80_din, z80_dout;
    logic       z80_iorq_n, z80_rd_n, z80_wr_n, z80_m1_n, z80_dout_en;
    logic [7:0] uart_dataout, uart_datain;
    logic       uart_avail, uart_buf_full, uart_read, uart_write, uart_tx_ready;

    uart_z80_port dut (
        .clk(clk), .reset(reset), .z80_addr(z80_addr), .z80_din(z80_din),
        .z80_iorq_n(z80_iorq_n), .z80_rd_n(z80_rd_n), .z80_wr_n(z80_wr_n),
        .z80_m1_n(z80_m1_n), .z80_dout(z80_dout), .z80_dout_en(z80_dout_en),
        .uart_dataout(uart_dataout), .uart_avail(uart_avail),
        .uart_buf_full(uart_buf_full), .uart_read(uart_read),
        .uart_datain(uart_datain), .uart_write(uart_write),
        .uart_tx_ready(uart_tx_ready)
    );

    always #5 clk = ~clk;

    int         vectors = 0;
    int         errors  = 0;
    logic [7:0] env_fifo[$];   // what the UART RX FIFO currently holds
    logic [7:0] rx_stream[$];  // bytes the CPU has still to read, oldest first
    logic [7:0] m_txq[$];      // bytes accepted by the port, not yet taken by the transmitter
    logic [7:0] sent[$];       // bytes the transmitter took, in order
    logic       m_ovf = 1'b0;
    int         rd_pulses = 0;
    int         wr_rises  = 0;
    logic       chk_rd = 1'b0;
    logic [7:0] exp_dout = 8'h00;
    int         tx_mode = M_NORMAL;
    int         busy_len = 100;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // RX FIFO emulation: pops on uart_read, presents the head byte.
    initial begin
        uart_avail = 1'b0;
        uart_dataout = 8'h00;
        forever begin
            @(posedge clk);
            if (uart_read === 1'b1) begin
                if (env_fifo.size() > 0) void'(env_fifo.pop_front());
                rd_pulses++;
            end
            #1;
            uart_avail   = (env_fifo.size() > 0);
            uart_dataout = (env_fifo.size() > 0) ? env_fifo[0] : 8'h00;
        end
    end

    // Transmitter emulation: goes busy two cycles after a write request.
    initial begin
        int wr_age;
        int busy_left;
        wr_age = 0;
        busy_left = 0;
        uart_tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (tx_mode)
                M_STALL: begin uart_tx_ready = 1'b0; wr_age = 0; busy_left = 0; end
                M_DEAF:  begin uart_tx_ready = 1'b1; wr_age = 0; busy_left = 0; end
                default: begin
                    if (busy_left > 0) begin
                        busy_left--;
                        if (busy_left == 0) uart_tx_ready = 1'b1;
                    end else if (!uart_tx_ready) begin
                        uart_tx_ready = 1'b1;
                    end else if (uart_write) begin
                        wr_age++;
                        if (wr_age == 3) begin
                            uart_tx_ready = 1'b0;
                            busy_left = busy_len;
                            wr_age = 0;
                            sent.push_back(uart_datain);
                            if (m_txq.size() > 0) void'(m_txq.pop_front());
                        end
                    end else begin
                        wr_age = 0;
                    end
                end
            endcase
        end
    end

    // Per-cycle comparison of the DUT outputs against the model.
    initial begin
        logic       prev_wr;
        logic       prev_rd;
        logic [7:0] held;
        prev_wr = 1'b0;
        prev_rd = 1'b0;
        held = 8'h00;
        forever begin
            @(negedge clk);
            if (chk_rd) begin
                chk("dout_en", z80_dout_en, 1'b1);
                chk("dout", z80_dout, exp_dout);
            end else begin
                chk("dout_en_off", z80_dout_en, 1'b0);
            end
            if (uart_read === 1'b1) begin
                chk("pop_nonempty", env_fifo.size() > 0, 1'b1);
                chk("pop_single", prev_rd, 1'b0);
            end
            if (uart_write === 1'b1 && !prev_wr) begin
                wr_rises++;
                chk("tx_pending", m_txq.size() > 0, 1'b1);
                if (m_txq.size() > 0) chk("tx_head", uart_datain, m_txq[0]);
                held = uart_datain;
            end else if (uart_write === 1'b1) begin
                chk("tx_hold", uart_datain, held);
            end
            prev_wr = (uart_write === 1'b1);
            prev_rd = (uart_read === 1'b1);
        end
    end

    function automatic logic [7:0] model_read(input logic [7:0] addr);
        if (addr == DATA) return (rx_stream.size() > 0) ? rx_stream[0] : 8'h00;
        return {3'b000, m_ovf, uart_buf_full, m_txq.size() == 0, m_txq.size() != 4,
                rx_stream.size() > 0};
    endfunction

    task automatic cpu_rd(input logic [7:0] addr, input logic [7:0] lit);
        @(posedge clk); #2;
        z80_addr = addr;
        @(posedge clk); #2;
        exp_dout = model_read(addr);
        z80_iorq_n = 1'b0;
        z80_rd_n = 1'b0;
        chk_rd = 1'b1;
        @(negedge clk);
        chk("in_literal", z80_dout, lit);
        repeat (6) @(posedge clk);
        #2;
        z80_iorq_n = 1'b1;
        z80_rd_n = 1'b1;
        chk_rd = 1'b0;
        repeat (6) @(posedge clk);
        if (addr == DATA && rx_stream.size() > 0) void'(rx_stream.pop_front());
        if (addr == STAT) m_ovf = 1'b0;
    endtask

    task automatic cpu_wr(input logic [7:0] addr, input logic [7:0] data);
        @(posedge clk); #2;
        z80_addr = addr;
        z80_din = data;
        @(posedge clk); #2;
        if (addr == DATA) begin
            if (m_txq.size() < 4) m_txq.push_back(data);
            else m_ovf = 1'b1;
        end
        z80_iorq_n = 1'b0;
        z80_wr_n = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        z80_iorq_n = 1'b1;
        z80_wr_n = 1'b1;
        repeat (6) @(posedge clk);
    endtask

    task automatic cpu_inta(input logic [7:0] addr);
        @(posedge clk); #2;
        z80_addr = addr;
        z80_m1_n = 1'b0;
        z80_iorq_n = 1'b0;
        z80_rd_n = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        z80_m1_n = 1'b1;
        z80_iorq_n = 1'b1;
        z80_rd_n = 1'b1;
        repeat (6) @(posedge clk);
    endtask

    task automatic rx_offer(input logic [7:0] b);
        env_fifo.push_back(b);
        rx_stream.push_back(b);
    endtask

    task automatic wait_tx_drain(input int limit);
        int n;
        n = 0;
        while ((m_txq.size() != 0 || !uart_tx_ready || uart_write) && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("tx_drain_in_time", n < limit, 1'b1);
        repeat (4) @(posedge clk);
    endtask

    // Advance negedge by negedge until uart_write equals val; n = negedges taken.
    task automatic wait_write(input logic val, input int limit, output int n);
        n = 0;
        while (uart_write !== val && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int rises0;
        reset = 1'b1;
        z80_addr = 8'h00;
        z80_din = 8'h00;
        z80_iorq_n = 1'b1;
        z80_rd_n = 1'b1;
        z80_wr_n = 1'b1;
        z80_m1_n = 1'b1;
        uart_buf_full = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_uart_read", uart_read, 1'b0);
        chk("rst_uart_write", uart_write, 1'b0);
        chk("rst_uart_datain", uart_datain, 8'h00);
        repeat (8) @(posedge clk);
        cpu_rd(STAT, 8'h06);
        uart_buf_full = 1'b1;
        cpu_rd(STAT, 8'h0E);
        uart_buf_full = 1'b0;

        // RX prefetch and consumption
        @(posedge clk); #2;
        rx_offer(8'h41);
        rx_offer(8'h42);
        repeat (10) @(posedge clk);
        chk("rx_first_pulse", rd_pulses, 1);
        cpu_rd(DATA, 8'h41);
        repeat (4) @(posedge clk);
        chk("rx_second_pulse", rd_pulses, 2);
        cpu_rd(STAT, 8'h07);
        cpu_rd(DATA, 8'h42);
        cpu_rd(STAT, 8'h06);
        cpu_rd(DATA, 8'h00);
        chk("rx_no_extra_pulse", rd_pulses, 2);

        // Interrupt acknowledge must not consume the latched byte
        @(posedge clk); #2;
        rx_offer(8'h99);
        repeat (10) @(posedge clk);
        cpu_inta(DATA);
        cpu_rd(DATA, 8'h99);
        chk("rx_pulses_after_inta", rd_pulses, 3);

        // Single transmit with a long busy period
        rises0 = wr_rises;
        busy_len = 100;
        cpu_wr(DATA, 8'h55);
        wait_tx_drain(400);
        chk("tx_single_request", wr_rises - rises0, 1);
        cpu_rd(STAT, 8'h06);

        // Queue fill with a stalled transmitter, overflow, status clear, drain
        tx_mode = M_STALL;
        repeat (3) @(posedge clk);
        for (int i = 1; i <= 5; i++) cpu_wr(DATA, 8'(i));
        cpu_rd(STAT, 8'h10);
        cpu_rd(STAT, 8'h00);
        cpu_wr(STAT, 8'hAA);
        cpu_rd(STAT, 8'h00);
        busy_len = 5;
        tx_mode = M_NORMAL;
        wait_tx_drain(2000);
        cpu_rd(STAT, 8'h06);
        chk("sent_count", sent.size(), 5);
        if (sent.size() == 5) begin
            chk("sent_0", sent[0], 8'h55);
            chk("sent_1", sent[1], 8'h01);
            chk("sent_2", sent[2], 8'h02);
            chk("sent_3", sent[3], 8'h03);
            chk("sent_4", sent[4], 8'h04);
        end

        // Transmitter never goes busy: timeout, retry, then reset mid-request
        tx_mode = M_DEAF;
        cpu_wr(DATA, 8'h77);
        @(negedge clk);
        wait_write(1'b0, 100, n);
        chk("first_req_ends", n < 100, 1'b1);
        wait_write(1'b1, 10, n);
        chk("retry_gap", n, 1);
        wait_write(1'b0, 200, n);
        chk("timeout_len", n, 64);
        wait_write(1'b1, 10, n);
        chk("retry_gap_2", n, 1);
        chk("retry_byte", uart_datain, 8'h77);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_abort_write", uart_write, 1'b0);
        m_txq.delete();
        m_ovf = 1'b0;
        @(posedge clk); #2;
        reset = 1'b0;
        tx_mode = M_NORMAL;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("rst_no_request", uart_write, 1'b0);
        cpu_rd(STAT, 8'h06);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
